// File: rtl/arm_operand_pkg.sv
// Shared types and widths for the operand encoder/decoder pair.
// imm_encoder build option: define IMM_ENCODER_EARLY_EXIT_EN for variable-latency search.
package arm_operand_pkg;

    localparam int DATA_W    = 32;
    localparam int ROT_STEPS = 16;
    localparam int ROT_W     = 4;
    localparam int IMM8_W    = 8;
    localparam int SHOP_W    = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } enc_state_t;

    // A 32-bit constant fits a 12-bit signed offset when bits [31:11]
    // are a pure sign extension of bit 11.
    function automatic logic mem_fits(input logic [DATA_W-1:0] v);
        return (v[DATA_W-1:11] == '0) || (v[DATA_W-1:11] == '1);
    endfunction

endpackage

// File: rtl/imm_rot_check.sv
// One rotation candidate: rotate the constant left by 2*rot and report
// whether the result fits in eight bits (i.e. ROR(imm8, 2*rot) == value).
module imm_rot_check
    import arm_operand_pkg::*;
(
    input  logic [DATA_W-1:0] value,
    input  logic [ROT_W-1:0]  rot,
    output logic              match,
    output logic [IMM8_W-1:0] imm8
);

    logic [2*DATA_W-1:0] w_dbl;
    logic [DATA_W-1:0]   w_cand;
    logic [5:0]          w_amt;

    // Rotate via a doubled word so a zero rotation needs no special case.
    assign w_amt  = {1'b0, rot, 1'b0};
    assign w_dbl  = {value, value} << w_amt;
    assign w_cand = w_dbl[2*DATA_W-1:DATA_W];

    assign match = ~|w_cand[DATA_W-1:IMM8_W];
    assign imm8  = w_cand[IMM8_W-1:0];

endmodule

// File: rtl/imm_encoder.sv
// Multi-cycle encoder: finds the 12-bit shift_operand that the operand
// generator expands back to a given 32-bit constant.
// Build option: IMM_ENCODER_EARLY_EXIT_EN -- leave the search on the first
// matching rotation; otherwise all rotations are always scanned.
module imm_encoder
    import arm_operand_pkg::*;
#(
    parameter int ROT_STEPS = arm_operand_pkg::ROT_STEPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mem,
    input  logic [DATA_W-1:0] value,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic [SHOP_W-1:0] shift_operand
);

    localparam logic [ROT_W-1:0] LAST_ROT = ROT_W'(ROT_STEPS - 1);

    enc_state_t        r_state;
    enc_state_t        w_state_next;
    logic              w_accept;
    logic              w_last;

    logic [DATA_W-1:0] r_value;
    logic [ROT_W-1:0]  r_rot;
    logic              r_found;
    logic [SHOP_W-1:0] r_res_shop;

    logic              r_done;
    logic              r_valid;
    logic [SHOP_W-1:0] r_shop;

    logic              w_match;
    logic [IMM8_W-1:0] w_imm8;

    // Single checker shared by every search cycle.
    imm_rot_check u_rot_check (
        .value (r_value),
        .rot   (r_rot),
        .match (w_match),
        .imm8  (w_imm8)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = mem ? DONE : SEARCH;
                end
            end
            SEARCH: begin
                w_last = (r_rot == LAST_ROT);
`ifdef IMM_ENCODER_EARLY_EXIT_EN
                if (w_match || w_last) begin
                    w_state_next = DONE;
                end
`else
                if (w_last) begin
                    w_state_next = DONE;
                end
`endif
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand capture and search datapath; the first match is kept so the
    // smallest rotation wins regardless of how long the scan runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value    <= '0;
            r_rot      <= '0;
            r_found    <= 1'b0;
            r_res_shop <= '0;
        end else if (w_accept) begin
            r_value <= value;
            r_rot   <= '0;
            if (mem && mem_fits(value)) begin
                r_found    <= 1'b1;
                r_res_shop <= value[SHOP_W-1:0];
            end else begin
                r_found    <= 1'b0;
                r_res_shop <= '0;
            end
        end else if (r_state == SEARCH) begin
            if (w_match && !r_found) begin
                r_found    <= 1'b1;
                r_res_shop <= {r_rot, w_imm8};
            end
            if (!w_last) begin
                r_rot <= r_rot + 1'b1;
            end
        end
    end

    // Registered outputs: the result becomes visible with the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_shop  <= '0;
        end else begin
            r_done <= (r_state == DONE);
            if (r_state == DONE) begin
                r_valid <= r_found;
                r_shop  <= r_res_shop;
            end
        end
    end

    assign busy          = (r_state != IDLE);
    assign done          = r_done;
    assign valid         = r_valid;
    assign shift_operand = r_shop;

endmodule

// File: tb/tb_imm_encoder.sv
// Randomised scoreboard bench for imm_encoder (both build options).
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mem;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        valid;
    logic [11:0] shift_operand;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    typedef struct {
        logic        m;
        logic [31:0] v;
        logic        valid;
        logic [11:0] shop;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    logic prev_done = 1'b0;

    imm_encoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mem           (mem),
        .value         (value),
        .busy          (busy),
        .done          (done),
        .valid         (valid),
        .shift_operand (shift_operand)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rol1(input logic [31:0] v, input int n);
        logic [31:0] r = v;
        for (int i = 0; i < n; i++) r = {r[30:0], r[31]};
        return r;
    endfunction

    function automatic logic [31:0] ror1(input logic [31:0] v, input int n);
        logic [31:0] r = v;
        for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
        return r;
    endfunction

    // Reference: smallest rotation whose left-rotated constant is below 256;
    // memory mode is a signed range test. Latency in spec cycles.
    function automatic exp_t model(input logic m, input logic [31:0] v);
        exp_t e;
        int   sv;
        e.m = m; e.v = v; e.valid = 1'b0; e.shop = 12'h000; e.lat = 18; e.acc = 0;
        if (m) begin
            sv = $signed(v);
            e.lat = 2;
            if (sv >= -2048 && sv <= 2047) begin
                e.valid = 1'b1;
                e.shop  = v[11:0];
            end
        end else begin
            for (int r = 0; r < 16; r++) begin
                logic [31:0] c = rol1(v, 2 * r);
                if (!e.valid && c < 32'd256) begin
                    e.valid = 1'b1;
                    e.shop  = {4'(r), c[7:0]};
`ifdef IMM_ENCODER_EARLY_EXIT_EN
                    e.lat = r + 3;
`endif
                end
            end
        end
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (prev_done) chk("done_one_cycle", {31'd0, done}, 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn mem=%0b value=%h valid=%0b shop=%h cycle=%0d", e.m, e.v,
                             valid, shift_operand, cyc - e.acc + 1);
                    chk("valid", {31'd0, valid}, {31'd0, e.valid});
                    chk("shift_operand", {20'd0, shift_operand}, {20'd0, e.shop});
                    chk("done_cycle", cyc - e.acc + 1, e.lat);
                    chk("busy_at_done", {31'd0, busy}, 32'd0);
                    if (e.valid && !e.m)
                        chk("reexpand", ror1({24'd0, shift_operand[7:0]}, 2 * shift_operand[11:8]), e.v);
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic issue(input logic m, input logic [31:0] v, input bit push, output int acc);
        exp_t e;
        @(negedge clk);
        start = 1'b1; mem = m; value = v;
        acc = cyc + 1;
        if (push) begin
            e = model(m, v);
            e.acc = acc;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0; mem = $urandom_range(0, 1); value = $urandom;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            chk("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic m, input logic [31:0] v);
        int acc;
        issue(m, v, 1'b1, acc);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          acc;
        logic [31:0] v;
        logic [31:0] imm_list[8];
        logic [31:0] mem_list[6];
        imm_list = '{32'h000000FF, 32'hFF000000, 32'hC000003F, 32'h00000101,
                     32'h00000000, 32'h000003FC, 32'h00000FF0, 32'h80000001};
        mem_list = '{32'hFFFFF800, 32'h00000800, 32'h000007FF, 32'hFFFFF7FF,
                     32'h00000000, 32'hFFFFFFFF};
        rst_n = 1'b0; start = 1'b0; mem = 1'b0; value = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_shop", {20'd0, shift_operand}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (imm_list[i]) run(1'b0, imm_list[i]);
        foreach (mem_list[i]) run(1'b1, mem_list[i]);

        // Extra start during SEARCH must be dropped.
        issue(1'b0, 32'h00000101, 1'b1, acc);
        repeat (3) @(negedge clk);
        start = 1'b1; mem = 1'b1; value = 32'h00000005;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (25) @(negedge clk);

        // Leave a nonzero result, then reset in search cycle 5.
        run(1'b0, 32'hFF000000);
        issue(1'b0, 32'h00000101, 1'b0, acc);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_shop", {20'd0, shift_operand}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        run(1'b0, 32'hC000003F);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: run(1'b0, $urandom);
                1: begin
                    v = ror1({24'd0, 8'($urandom)}, 2 * $urandom_range(0, 15));
                    run(1'b0, v);
                end
                2: run(1'b1, {{20{v[11]}}, v[11:0]} ^ 32'($urandom_range(0, 1) << 11));
                default: run(1'b1, $urandom);
            endcase
            v = $urandom;
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
